// File: rtl/cmd_reader_pkg.sv
// Shared constants for the command reader: FSM encodings, command IDs,
// character classes and the fixed command string table.
package cmd_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_MATCH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] CMD_NONE = 2'd0;
   localparam logic [1:0] CMD_HELP = 2'd1;
   localparam logic [1:0] CMD_LED  = 2'd2;
   localparam logic [1:0] CMD_PING = 2'd3;

   localparam logic [7:0] CH_CR       = 8'h0D;
   localparam logic [7:0] CH_LF       = 8'h0A;
   localparam logic [7:0] CH_BS       = 8'h08;
   localparam logic [7:0] CH_DEL      = 8'h7F;
   localparam logic [7:0] CH_PRINT_LO = 8'h20;
   localparam logic [7:0] CH_PRINT_HI = 8'h7E;
   localparam logic [7:0] CH_UPPER_LO = 8'h41;
   localparam logic [7:0] CH_UPPER_HI = 8'h5A;
   localparam logic [7:0] CH_CASE_OFS = 8'h20;

   localparam int CMD_NUM  = 3;
   localparam int CMD_MAXC = 8;

   typedef logic [CMD_MAXC-1:0][7:0] cmd_str_t;

   // Byte [0] holds the first character, so the literals read right-to-left.
   localparam cmd_str_t   CMD_STR [CMD_NUM] = '{
      {32'h0, "p", "l", "e", "h"},
      {40'h0, "d", "e", "l"},
      {32'h0, "g", "n", "i", "p"}
   };
   localparam int         CMD_LEN [CMD_NUM] = '{4, 3, 4};
   localparam logic [1:0] CMD_ID  [CMD_NUM] = '{CMD_HELP, CMD_LED, CMD_PING};

   function automatic logic [7:0] fold_case(input logic [7:0] b);
      if (b >= CH_UPPER_LO && b <= CH_UPPER_HI) return b + CH_CASE_OFS;
      return b;
   endfunction

endpackage

// File: rtl/cmd_reader_if.sv
// Sequencer-facing handshake plus the UART rx byte stream for the command reader.
interface cmd_reader_if;
   logic       enable;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [1:0] cmd_id;
   logic       cmd_error;
   logic       cmd_done;
   logic [1:0] reader_state;

   modport master (
      output enable, rx_data, rx_valid,
      input  cmd_id, cmd_error, cmd_done, reader_state
   );

   modport slave (
      input  enable, rx_data, rx_valid,
      output cmd_id, cmd_error, cmd_done, reader_state
   );
endinterface

// File: rtl/cmd_reader_match.sv
// Combinational lookup of the line buffer against the command table;
// a hit needs both identical characters and identical length.
module cmd_reader_match
   import cmd_reader_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int PTR_W   = 4
) (
   input  logic [MAX_LEN-1:0][7:0] buf_i,
   input  logic [PTR_W-1:0]        len_i,
   output logic                    match_o,
   output logic [1:0]              id_o
);

   // Lengths must agree first, so comparing the common prefix is enough.
   localparam int NCMP = (MAX_LEN < CMD_MAXC) ? MAX_LEN : CMD_MAXC;

   logic hit;

   always_comb begin
      match_o = 1'b0;
      id_o    = CMD_NONE;
      hit     = 1'b0;
      for (int c = 0; c < CMD_NUM; c++) begin
         hit = (int'(len_i) == CMD_LEN[c]);
         for (int i = 0; i < NCMP; i++) begin
            if (i < CMD_LEN[c] && buf_i[i] != CMD_STR[c][i]) hit = 1'b0;
         end
         if (hit && !match_o) begin
            match_o = 1'b1;
            id_o    = CMD_ID[c];
         end
      end
   end

endmodule

// File: rtl/cmd_reader.sv
// Assembles UART bytes into a line, decodes it against the command table and
// hands the result to the sequencer over the enable/done handshake.
//
// state | meaning
// IDLE  | waiting for enable, outputs cleared
// READ  | collecting bytes until CR/LF
// MATCH | one cycle, latch table lookup result
// DONE  | cmd_done high until enable drops
module cmd_reader
   import cmd_reader_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int PTR_W   = 4
) (
   input  logic         clk,
   input  logic         rst,
   cmd_reader_if.slave  bus
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_t                  state_q, state_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic                    ovf_q, ovf_d;
   logic                    bad_q, bad_d;
   logic [MAX_LEN-1:0][7:0] buf_q, buf_d;
   logic [1:0]              id_q, id_d;
   logic                    err_q, err_d;

   logic                    match;
   logic [1:0]              match_id;
   logic [7:0]              rx_b;

   cmd_reader_match #(.MAX_LEN(MAX_LEN), .PTR_W(PTR_W)) u_match (
      .buf_i   (buf_q),
      .len_i   (ptr_q),
      .match_o (match),
      .id_o    (match_id)
   );

   assign rx_b = bus.rx_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         ovf_q   <= 1'b0;
         bad_q   <= 1'b0;
         buf_q   <= '0;
         id_q    <= CMD_NONE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ovf_q   <= ovf_d;
         bad_q   <= bad_d;
         buf_q   <= buf_d;
         id_q    <= id_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ovf_d   = ovf_q;
      bad_d   = bad_q;
      buf_d   = buf_q;
      id_d    = id_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            id_d  = CMD_NONE;
            err_d = 1'b0;
            if (bus.enable) begin
               ptr_d   = '0;
               ovf_d   = 1'b0;
               bad_d   = 1'b0;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (!bus.enable) begin
               state_d = ST_IDLE;
            end else if (bus.rx_valid) begin
               if (rx_b == CH_CR || rx_b == CH_LF) begin
                  // A bare terminator with nothing pending is line noise, not a command.
                  if (ptr_q != '0 || ovf_q || bad_q) state_d = ST_MATCH;
               end else if (rx_b == CH_BS || rx_b == CH_DEL) begin
                  if (ptr_q != '0 && !ovf_q) ptr_d = ptr_q - PTR_W'(1);
               end else if (rx_b >= CH_PRINT_LO && rx_b <= CH_PRINT_HI) begin
                  if (int'(ptr_q) < MAX_LEN) begin
                     buf_d[ptr_q[IDX_W-1:0]] = fold_case(rx_b);
                     ptr_d = ptr_q + PTR_W'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else begin
                  bad_d = 1'b1;
               end
            end
         end
         ST_MATCH: begin
            if (ovf_q || bad_q || !match) begin
               id_d  = CMD_NONE;
               err_d = 1'b1;
            end else begin
               id_d  = match_id;
               err_d = 1'b0;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (!bus.enable) begin
               id_d    = CMD_NONE;
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.cmd_id       = id_q;
   assign bus.cmd_error    = err_q;
   assign bus.cmd_done     = (state_q == ST_DONE);
   assign bus.reader_state = state_q;

endmodule

// File: tb/tb_cmd_reader.sv
// Directed bench for cmd_reader: a table of command lines with expected
// results, plus hand-written sequences for latency, empty lines, reset and abort.
module tb_cmd_reader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   npass = 0;
   int   ntot  = 0;

   cmd_reader_if bus();

   cmd_reader #(.MAX_LEN(8), .PTR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      txt;
      logic [1:0] exp_id;
      logic       exp_err;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input int got, input int exp);
      ntot++;
      if (got == exp) npass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
   endtask

   task automatic start_cmd();
      @(negedge clk);
      bus.enable = 1'b1;
   endtask

   task automatic wait_done(input string name);
      int seen;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.cmd_done) begin
            seen = 1;
            break;
         end
      end
      check({name, "_done_seen"}, seen, 1);
   endtask

   task automatic end_cmd(input string name);
      @(negedge clk);
      bus.enable = 1'b0;
      @(posedge clk);
      #1;
      check({name, "_idle_state"}, int'(bus.reader_state), 0);
      check({name, "_idle_done"}, int'(bus.cmd_done), 0);
      check({name, "_idle_id"}, int'(bus.cmd_id), 0);
   endtask

   task automatic run_cmd(input string name, input string s, input int exp_id, input int exp_err);
      start_cmd();
      send_str(s, 2);
      wait_done(name);
      check({name, "_id"}, int'(bus.cmd_id), exp_id);
      check({name, "_err"}, int'(bus.cmd_error), exp_err);
      end_cmd(name);
   endtask

   initial begin
      vecs[0]  = '{"HeLp\012",            2'd1, 1'b0};
      vecs[1]  = '{"lex\010d\015",        2'd2, 1'b0};
      vecs[2]  = '{"\177ping\015",        2'd3, 1'b0};
      vecs[3]  = '{"pingpongx\015",       2'd0, 1'b1};
      vecs[4]  = '{"pi\001ng\015",        2'd0, 1'b1};
      vecs[5]  = '{"pong\015",            2'd0, 1'b1};
      vecs[6]  = '{"le\015",              2'd0, 1'b1};
      vecs[7]  = '{"leds\015",            2'd0, 1'b1};
      vecs[8]  = '{"LED\015\012",         2'd2, 1'b0};
      vecs[9]  = '{"pingpong\015",        2'd0, 1'b1};
      vecs[10] = '{"pingpongx\010\015",   2'd0, 1'b1};
      vecs[11] = '{"help \015",           2'd0, 1'b1};

      bus.enable   = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", int'(bus.reader_state), 0);
      check("rst_done", int'(bus.cmd_done), 0);
      check("rst_id", int'(bus.cmd_id), 0);
      check("rst_err", int'(bus.cmd_error), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Slow "led" then exact two-cycle latency from the CR strobe.
      start_cmd();
      send_str("led", 100);
      @(negedge clk);
      bus.rx_data  = 8'h0D;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      check("lat_n1_state", int'(bus.reader_state), 2);
      check("lat_n1_done", int'(bus.cmd_done), 0);
      @(posedge clk);
      #1;
      check("lat_n2_done", int'(bus.cmd_done), 1);
      check("lat_id", int'(bus.cmd_id), 2);
      check("lat_err", int'(bus.cmd_error), 0);
      repeat (5) @(posedge clk);
      #1;
      check("lat_hold_id", int'(bus.cmd_id), 2);
      end_cmd("lat");

      for (int i = 0; i < 12; i++)
         run_cmd($sformatf("v%0d", i), vecs[i].txt, int'(vecs[i].exp_id), int'(vecs[i].exp_err));

      // Bare CR is ignored; the following line still decodes.
      start_cmd();
      send_byte(8'h0D, 4);
      check("empty_state", int'(bus.reader_state), 1);
      check("empty_done", int'(bus.cmd_done), 0);
      send_str("ping\015", 2);
      wait_done("empty");
      check("empty_id", int'(bus.cmd_id), 3);
      end_cmd("empty");

      // Reset in the middle of a line.
      start_cmd();
      send_str("pi", 2);
      @(negedge clk);
      rst = 1'b1;
      bus.enable = 1'b0;
      #1;
      check("mrst_state", int'(bus.reader_state), 0);
      check("mrst_done", int'(bus.cmd_done), 0);
      check("mrst_id", int'(bus.cmd_id), 0);
      check("mrst_err", int'(bus.cmd_error), 0);
      @(negedge clk);
      rst = 1'b0;
      run_cmd("post_rst", "help\015", 1, 0);

      // Enable dropped mid-line aborts without a result.
      start_cmd();
      send_str("pi", 2);
      @(negedge clk);
      bus.enable = 1'b0;
      @(posedge clk);
      #1;
      check("abort_state", int'(bus.reader_state), 0);
      send_str("ng\015", 2);
      repeat (5) @(posedge clk);
      #1;
      check("abort_done", int'(bus.cmd_done), 0);
      check("abort_state2", int'(bus.reader_state), 0);
      run_cmd("post_abort", "ping\015", 3, 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/cmd_reader.md
Name: cmd_reader

Overview:
Upstream stage of the command path. Consumes bytes from the UART receiver and assembles them into a line buffer until a terminator arrives. It then decodes the line against a fixed command table and reports a command ID, or an error, to the top-level sequencer through an enable/done handshake. This is the same handshake the start stage uses.

Parameters:
MAX_LEN, 8, maximum command length in characters; buffer depth.
PTR_W, 4, write-pointer width; must hold 0..MAX_LEN, i.e. clog2(MAX_LEN+1).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
enable  input  1  sequencer request to read one command; held high until cmd_done is seen
rx_data  input  8  received byte from UART rx
rx_valid  input  1  single-cycle strobe; rx_data is valid in that cycle
cmd_id  output  2  decoded command: 0 none/invalid, 1 "help", 2 "led", 3 "ping"
cmd_error  output  1  line was unknown, overflowed, or contained an illegal byte
cmd_done  output  1  result valid; cmd_id and cmd_error are stable while high
reader_state  output  2  current FSM state, for debug and sequencer

Behaviour:
- Reset (async assert, sync release): state IDLE, ptr=0, overflow/bad flags=0, cmd_id=0, cmd_error=0, cmd_done=0. Buffer contents are don't-care.
- FSM states:
  - IDLE=0: outputs cleared. If enable=1: ptr<=0, flags<=0, go READ.
  - READ=1: each accepted byte is classified when rx_valid=1:
    - 0x0D or 0x0A, ptr=0 and no flags set: empty line; ignored, stay READ.
    - 0x0D or 0x0A otherwise: go MATCH.
    - 0x08 or 0x7F: if ptr>0 and overflow=0, ptr<=ptr-1. Otherwise no effect.
    - 0x41-0x5A: folded to lowercase (add 0x20), then stored as printable.
    - 0x20-0x7E: if ptr<MAX_LEN, buf[ptr]<=byte and ptr<=ptr+1; else overflow<=1 (sticky) and byte discarded.
    - Any other byte: bad<=1 (sticky) and byte discarded.
  - MATCH=2: single cycle. Compare buf[0..ptr-1] plus length against the table in cmd_pkg.
    - If overflow or bad is set, or there is no match: cmd_id<=0, cmd_error<=1.
    - Otherwise cmd_id<=matched ID, cmd_error<=0.
    - Go DONE.
  - DONE=3: cmd_done=1; cmd_id and cmd_error held. Go IDLE when enable=0.
- Latency: terminator accepted in cycle N; MATCH in N+1; cmd_done=1 from N+2.
- Bytes with rx_valid in IDLE, MATCH or DONE are dropped. No buffering across commands.
- CR immediately followed by LF: the LF arrives in DONE/IDLE and is dropped, or arrives in the next READ as an empty line and is ignored.
- enable=0 while in READ: abort to IDLE next cycle; partial line discarded; no cmd_done.
- rst mid-operation: immediate return to reset values; the next command needs a fresh enable.
- Matching requires exact length: "le" and "leds" do not match "led".

Decomposition:
- cmd_pkg holds:
  - state encodings (IDLE/READ/MATCH/DONE)
  - command ID constants
  - character constants (CR, LF, BS, DEL, printable bounds, case offset)
  - command string table (bytes and lengths)
- One sub-module, cmd_match: compares the buffer against the table and outputs match/ID. It is sampled by the parent in MATCH.

Test Plan:
- Reset, enable=1, send "led"+0x0D, one byte per 100 cycles -> cmd_done=1 exactly 2 cycles after the CR strobe; cmd_id=2; cmd_error=0.
- Send "HeLp"+0x0A -> cmd_id=1, cmd_error=0. Then drop enable -> cmd_done=0 and reader_state=IDLE the next cycle.
- Send "lex",0x08,"d",0x0D -> cmd_id=2. Send 0x7F on an empty buffer, then "ping",0x0D -> cmd_id=3.
- Send "pingpongx"+0x0D (9 chars, MAX_LEN=8) -> cmd_error=1, cmd_id=0. Send "pi",0x01,"ng",0x0D -> cmd_error=1. Send "pong",0x0D -> cmd_error=1.
- Send 0x0D alone, then "ping",0x0D -> no cmd_done after the first CR (state stays READ); cmd_id=3 after the second.
- Send "pi", then assert rst for 1 cycle mid-byte-stream -> all outputs 0, state IDLE. Re-enable and send "help",0x0D -> cmd_id=1. Repeat the test with enable dropped after "pi" -> IDLE with no cmd_done.
